classifier_feed_seq: RTL

Sequential front-end for the combinational classifier core `top`, the block that directly feeds it. It accepts input features one at a time over a valid/ready stream and packs them into the core's flat `inp` vector. It holds each packed vector stable for a fixed settle time, then captures the core's `out` and presents it downstream on a valid/ready result port. A shadow buffer lets the next feature vector load while the current inference settles or waits on the consumer.

---
 rtl/classifier_pkg.sv | 19 +
 rtl/feature_shadow_buf.sv | 47 ++++
 rtl/classifier_feed_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/classifier_pkg.sv
// Shared types and default constants for the classifier feed front-end.
`timescale 1ns/1ps
package classifier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD
   } feed_state_t;

   localparam int NUM_A      = 6;
   localparam int WIDTH_A    = 4;
   localparam int OUTWIDTH   = 19;
   localparam int SETTLE_MAX = 255;

   // Width of a counter able to hold 0..SETTLE_MAX.
   localparam int CNT_W = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/feature_shadow_buf.sv
// Shadow buffer: packs streamed features into NUM_A slots so the next vector
// can load while the presented one settles or waits on the consumer.
`timescale 1ns/1ps
module feature_shadow_buf #(
   parameter int NUM_A   = 6,
   parameter int WIDTH_A = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   input  logic [WIDTH_A-1:0]       s_data,
   output logic                     s_ready,
   input  logic                     take,
   output logic [NUM_A*WIDTH_A-1:0] shadow,
   output logic                     shadow_full
);
   import classifier_pkg::*;

   localparam int IDXW = (NUM_A > 1) ? $clog2(NUM_A) : 1;

   logic [IDXW-1:0] idx;
   logic            accept;

   assign s_ready = !shadow_full;
   assign accept  = s_valid && s_ready;

   // Slot write, index advance and full flag; take only occurs while full,
   // so it can never coincide with an accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow      <= '0;
         idx         <= '0;
         shadow_full <= 1'b0;
      end else if (accept) begin
         shadow[idx*WIDTH_A +: WIDTH_A] <= s_data;
         if (idx == IDXW'(NUM_A - 1)) begin
            idx         <= '0;
            shadow_full <= 1'b1;
         end else begin
            idx <= idx + 1'b1;
         end
      end else if (take) begin
         shadow_full <= 1'b0;
      end
   end

endmodule

// File: rtl/classifier_feed_seq.sv
// Sequential front-end for the classifier core: presents packed feature
// vectors, waits a fixed settle time, then offers the core result downstream.
`timescale 1ns/1ps
module classifier_feed_seq #(
   parameter int NUM_A    = 6,
   parameter int WIDTH_A  = 4,
   parameter int OUTWIDTH = 19,
   parameter int SETTLE   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   input  logic [WIDTH_A-1:0]       s_data,
   output logic                     s_ready,
   output logic [NUM_A*WIDTH_A-1:0] inp,
   input  logic [OUTWIDTH-1:0]      clf_out,
   output logic                     m_valid,
   output logic [OUTWIDTH-1:0]      m_data,
   input  logic                     m_ready,
   output logic [15:0]              infer_cnt
);
   import classifier_pkg::*;

   feed_state_t                 state, state_nxt;
   logic [CNT_W-1:0]            cnt;
   logic [NUM_A*WIDTH_A-1:0]    shadow;
   logic                        shadow_full;
   logic                        take;
   logic                        capture;
   logic                        done;

   feature_shadow_buf #(
      .NUM_A   (NUM_A),
      .WIDTH_A (WIDTH_A)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .take        (take),
      .shadow      (shadow),
      .shadow_full (shadow_full)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state plus transfer / capture / handshake strobes.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      capture   = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (shadow_full) begin
               take      = 1'b1;
               state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (m_valid && m_ready) begin
               done = 1'b1;
               if (shadow_full) begin
                  take      = 1'b1;
                  state_nxt = ST_SETTLE;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Presented vector, settle counter, result registers and handshake count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inp       <= '0;
         cnt       <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         infer_cnt <= '0;
      end else begin
         if (take) begin
            inp <= shadow;
            cnt <= CNT_W'(SETTLE - 1);
         end else if (state == ST_SETTLE && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (capture) begin
            m_data  <= clf_out;
            m_valid <= 1'b1;
         end else if (done) begin
            m_valid <= 1'b0;
         end
         if (done) infer_cnt <= infer_cnt + 1'b1;
      end
   end

endmodule
